// File: rtl/pwm_cfg_pkg.sv
// ---------------------------------------------------------------------------
// pwm_cfg_pkg
// Purpose : Shared constants for the PWM configuration sequencer. It holds
//           the register map (addresses 0..4), the default register count
//           and the sequencer FSM state type.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package pwm_cfg_pkg;

  localparam int NUM_REGS_DEF = 5;

  // Register map
  localparam int ADDR_EN_OUT_7_0  = 0;
  localparam int ADDR_EN_OUT_15_8 = 1;
  localparam int ADDR_EN_PWM_7_0  = 2;
  localparam int ADDR_EN_PWM_15_8 = 3;
  localparam int ADDR_PWM_DUTY    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/cfg_reg_slot.sv
// ---------------------------------------------------------------------------
// cfg_reg_slot
// Purpose : One configuration slot, made of a shadow register, an active
//           register and a dirty bit. Writes land in the shadow register and
//           mark the slot dirty. A commit copies a dirty shadow into the
//           active register and then clears the dirty bit.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset; clears the whole slot
//           wr_en_i  - accepted write targeting this slot
//           wr_data_i- write data
//           commit_i - commit cycle (sequencer in COMMIT)
//           active_o - active register value
// ---------------------------------------------------------------------------
module cfg_reg_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       commit_i,
  output logic [7:0] active_o
);

  logic [7:0] shadow_q, shadow_d;
  logic [7:0] active_q, active_d;
  logic       dirty_q,  dirty_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    if (commit_i) begin
      if (dirty_q) active_d = shadow_q;
      dirty_d = 1'b0;
    end
    // A write cannot coincide with a commit (wr_ready is low in COMMIT).
    // If one did, the write must still be marked dirty, so it goes last.
    if (wr_en_i) begin
      shadow_d = wr_data_i;
      dirty_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= 8'h00;
      active_q <= 8'h00;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_cfg_sequencer
// Purpose : Double-buffered PWM configuration registers. Writes from the SPI
//           decoder update shadow registers. All pending writes are applied
//           to the active registers together, one cycle after the PWM period
//           wraps, so the PWM never sees a half-updated configuration.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           wr_valid/wr_ready        - write handshake
//           wr_addr, wr_data         - write target and data
//           period_end               - period wrap pulse from the PWM counter
//           en_out_7_0 .. pwm_duty   - active registers 0..4
//           pending                  - uncommitted shadow data present
//           addr_err                 - sticky invalid-address write flag
//           rd_addr, rd_data         - readback of active registers, present
//                                      only when PWM_CFG_READBACK_EN is defined
// Macro   : PWM_CFG_READBACK_EN enables the readback port and its mux.
// ---------------------------------------------------------------------------
module pwm_cfg_sequencer
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              period_end,
  output logic [7:0]        en_out_7_0,
  output logic [7:0]        en_out_15_8,
  output logic [7:0]        en_pwm_7_0,
  output logic [7:0]        en_pwm_15_8,
  output logic [7:0]        pwm_duty,
  output logic              pending,
`ifdef PWM_CFG_READBACK_EN
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
`endif
  output logic              addr_err
);

  // Mapped outputs need indices 0..4 even if NUM_REGS is smaller.
  localparam int NPAD = (NUM_REGS > 5) ? NUM_REGS : 5;

  state_e     state_q, state_d;
  logic       err_q, err_d;
  logic       wr_fire, addr_ok, wr_ok, commit;
  logic [7:0] act [NPAD];

  assign wr_ready = (state_q != ST_COMMIT);
  assign pending  = (state_q != ST_IDLE);
  assign addr_err = err_q;
  assign commit   = (state_q == ST_COMMIT);

  assign wr_fire = wr_valid && wr_ready;
  assign addr_ok = (int'(wr_addr) < NUM_REGS);
  assign wr_ok   = wr_fire && addr_ok;

  always_comb begin
    state_d = state_q;
    err_d   = err_q | (wr_fire && !addr_ok);
    case (state_q)
      ST_IDLE:    if (wr_ok) state_d = ST_PENDING;
      // A write accepted on this same edge is already in its shadow register
      // when COMMIT copies, so it joins this commit.
      ST_PENDING: if (period_end) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NPAD; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_real
      cfg_reg_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok && (wr_addr == ADDR_W'(i))),
        .wr_data_i (wr_data),
        .commit_i  (commit),
        .active_o  (act[i])
      );
    end else begin : g_pad
      assign act[i] = 8'h00;
    end
  end

  assign en_out_7_0  = act[ADDR_EN_OUT_7_0];
  assign en_out_15_8 = act[ADDR_EN_OUT_15_8];
  assign en_pwm_7_0  = act[ADDR_EN_PWM_7_0];
  assign en_pwm_15_8 = act[ADDR_EN_PWM_15_8];
  assign pwm_duty    = act[ADDR_PWM_DUTY];

`ifdef PWM_CFG_READBACK_EN
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = act[i];
    end
  end
`endif

endmodule
